uart_rx_framed: RTL and testbench
=================================

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, giving clock cycles per bit (27 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter STOP_BITS, default 1, giving stop bits checked per frame; legal values 1, 2.
REQ-004 SHALL have parameter PARITY_MODE, default 0, selecting parity: 0 none, 1 odd, 2 even; it is honoured only when UART_RX_PARITY_EN is defined.
REQ-005 SHALL have the following ports, clock and reset first:
- i_Clock  in  1  single clock for all logic
- i_Reset  in  1  synchronous, active-high reset
- i_Rx_Serial  in  1  asynchronous serial line, idle high
- o_Rx_Valid  out  1  holding register contains an unaccepted frame
- i_Rx_Ready  in  1  consumer accepts the frame in the cycle where o_Rx_Valid && i_Rx_Ready
- o_Rx_Byte  out  8  received data, LSB first on the line; bits above DATA_BITS are zero
- o_Frame_Err  out  1  held frame had a stop bit sampled low
- o_Parity_Err  out  1  held frame failed the parity check
- o_Overrun  out  1  sticky; set when a completed frame was dropped
- o_Busy  out  1  FSM is not in IDLE

Function
REQ-006 SHALL pass i_Rx_Serial through a two-flop synchroniser; both flops SHALL reset to 1.
REQ-007 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with the following transitions:
- IDLE -> START on synchronised line low.
- START: at count (CLKS_PER_BIT-1)/2, a low sample goes to DATA with the count cleared; a high sample (glitch) returns to IDLE.
- DATA: sample every CLKS_PER_BIT cycles for DATA_BITS samples, then go to PARITY if parity is active, else to STOP.
- PARITY: take one sample, then go to STOP.
- STOP: take STOP_BITS samples, each CLKS_PER_BIT apart; after the final sample go directly to IDLE, with no cleanup wait.
REQ-008 SHALL size the bit counter as $clog2(CLKS_PER_BIT) bits and the index counter as $clog2(DATA_BITS+1) bits; neither counter SHALL wrap within a frame.
REQ-009 SHALL set o_Frame_Err for a frame if any stop-bit sample is 0; the frame SHALL still be delivered.
REQ-010 SHALL, on completion, load byte and error flags into the holding register and assert o_Rx_Valid on the cycle after the final stop-bit sample.
REQ-011 SHALL hold o_Rx_Valid, o_Rx_Byte and both error flags stable until an o_Rx_Valid && i_Rx_Ready cycle; if no new frame completes that cycle, o_Rx_Valid SHALL deassert on the next cycle.
REQ-012 SHALL, when a frame completes while o_Rx_Valid=1 and i_Rx_Ready=0, keep the old frame, drop the new one, and set o_Overrun.
REQ-013 SHALL, when a frame completes in the same cycle as an accept, load the new frame, keep o_Rx_Valid=1, and leave o_Overrun unchanged.
REQ-014 SHALL keep o_Overrun set until i_Reset.
REQ-015 SHALL ignore i_Rx_Ready when o_Rx_Valid=0.

Reset
REQ-016 SHALL, while i_Reset=1 at a clock edge, force FSM=IDLE, all counters=0, o_Rx_Valid=0, o_Rx_Byte=0, o_Frame_Err=0, o_Parity_Err=0, o_Overrun=0, o_Busy=0.
REQ-017 SHALL abandon a frame in progress when reset is applied mid-frame, with no partial frame delivered; reception SHALL resume on the next falling edge after reset deasserts.

Configuration
REQ-018 SHALL, with UART_RX_PARITY_EN defined and PARITY_MODE 1 or 2, include the PARITY state and drive o_Parity_Err from the XOR of the data bits and the parity sample (odd: error if XOR=0; even: error if XOR=1).
REQ-019 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and parity logic, tie o_Parity_Err to 0, and ignore PARITY_MODE.

Structure
REQ-020 SHALL take the FSM state enum and the PARITY_NONE/ODD/EVEN constants from shared package uart_pkg.
REQ-021 SHALL contain exactly one sub-module, uart_sync2: the two-flop synchroniser with a reset value parameter.

Verification
REQ-022 SHALL cover: CLKS_PER_BIT=16, 8N1, send 0xA5 with ready=1 -> one o_Rx_Valid pulse, o_Rx_Byte=0xA5, all error flags 0.
REQ-023 SHALL cover: send 0x3C with stop bit driven 0 -> o_Rx_Byte=0x3C, o_Frame_Err=1.
REQ-024 SHALL cover: 4-cycle low glitch on the idle line -> FSM back to IDLE, o_Rx_Valid never asserts.
REQ-025 SHALL cover: back-to-back 0x11 then 0x22 with ready=0 -> o_Rx_Byte=0x11, o_Overrun=1; raise ready -> 0x11 accepted, o_Rx_Valid drops.
REQ-026 SHALL cover: UART_RX_PARITY_EN, DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2, send 0x41 with parity bit 1 -> o_Rx_Byte=0x41, o_Parity_Err=1.
REQ-027 SHALL cover: i_Reset pulsed during data bit 3, then send 0x5A -> no output for the aborted frame; o_Rx_Byte=0x5A, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and parity mode selectors.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops load RESET_VAL on reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver with stop-bit framing check, overrun detection and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to build the optional parity bit check selected by PARITY_MODE.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_MODE  = PARITY_NONE
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_Valid,
  input  logic       i_Rx_Ready,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfCnt  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] IdxLast  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] StopLast = IW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit ParityBuilt = 1'b1;
`else
  localparam bit ParityBuilt = 1'b0;
`endif
  localparam bit ParityOn = ParityBuilt &&
                            ((PARITY_MODE == PARITY_ODD) || (PARITY_MODE == PARITY_EVEN));

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        clkCnt_q, clkCnt_d;
  logic [IW-1:0]        bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stopErr_q, stopErr_d;
  logic                 rxSync;
  logic                 frameDone;
  logic                 frameErrNew;
  logic                 parErrNew;

  logic       valid_q;
  logic [7:0] byte_q;
  logic       frameErr_q;
  logic       parErr_q;
  logic       overrun_q;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (i_Clock),
    .rst_i (i_Reset),
    .d_i   (i_Rx_Serial),
    .q_o   (rxSync)
  );

`ifdef UART_RX_PARITY_EN
  logic parBit_q, parBit_d;
  logic parXor;

  assign parXor    = (^shift_q) ^ parBit_q;
  assign parErrNew = ParityOn && ((PARITY_MODE == PARITY_ODD) ? ~parXor : parXor);
`else
  assign parErrNew = 1'b0;
`endif

  // The final stop sample is folded in here because the holding register loads on that same edge.
  assign frameErrNew = stopErr_q | ~rxSync;

  always_comb begin
    state_d   = state_q;
    clkCnt_d  = clkCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    stopErr_d = stopErr_q;
    frameDone = 1'b0;
`ifdef UART_RX_PARITY_EN
    parBit_d  = parBit_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rxSync) begin
          state_d   = START;
          clkCnt_d  = '0;
          bitIdx_d  = '0;
          stopErr_d = 1'b0;
        end
      end
      START: begin
        if (clkCnt_q == HalfCnt) begin
          clkCnt_d = '0;
          state_d  = rxSync ? IDLE : DATA;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      DATA: begin
        if (clkCnt_q == BitLast) begin
          clkCnt_d = '0;
          shift_d  = {rxSync, shift_q[DATA_BITS-1:1]};
          if (bitIdx_q == IdxLast) begin
            bitIdx_d = '0;
            state_d  = ParityOn ? PARITY : STOP;
          end else begin
            bitIdx_d = bitIdx_q + IW'(1);
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clkCnt_q == BitLast) begin
          clkCnt_d = '0;
          parBit_d = rxSync;
          state_d  = STOP;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (clkCnt_q == BitLast) begin
          clkCnt_d = '0;
          if (!rxSync) stopErr_d = 1'b1;
          if (bitIdx_q == StopLast) begin
            bitIdx_d  = '0;
            state_d   = IDLE;
            frameDone = 1'b1;
          end else begin
            bitIdx_d = bitIdx_q + IW'(1);
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      clkCnt_q  <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      stopErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBit_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clkCnt_q  <= clkCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      stopErr_q <= stopErr_d;
`ifdef UART_RX_PARITY_EN
      parBit_q  <= parBit_d;
`endif
    end
  end

  // A completing frame is dropped only if the held one is not being accepted this cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      valid_q    <= 1'b0;
      byte_q     <= '0;
      frameErr_q <= 1'b0;
      parErr_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (frameDone) begin
      if (valid_q && !i_Rx_Ready) begin
        overrun_q <= 1'b1;
      end else begin
        valid_q    <= 1'b1;
        byte_q     <= 8'(shift_q);
        frameErr_q <= frameErrNew;
        parErr_q   <= parErrNew;
      end
    end else if (valid_q && i_Rx_Ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_Rx_Valid   = valid_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Frame_Err  = frameErr_q;
  assign o_Parity_Err = parErr_q;
  assign o_Overrun    = overrun_q;
  assign o_Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench for uart_rx_framed: DUT A is 8N1, DUT B is 7E2 (7N2 when UART_RX_PARITY_EN is undefined).
// Frames are checked against a bit-level frame model; accepted frames are captured by a negedge monitor.
module tb_uart_rx_framed;

  localparam int BIT_CLKS = 16;

  logic clk = 1'b0;
  logic reset;

  logic       rxA, readyA, validA, ferrA, perrA, ovrA, busyA;
  logic [7:0] byteA;
  logic       rxB, readyB, validB, ferrB, perrB, ovrB, busyB;
  logic [7:0] byteB;

  int vecCount = 0;
  int errCount = 0;

  logic [9:0] gotA[$];
  logic [9:0] gotB[$];
  int         validRisesA = 0;
  logic       validAPrev  = 1'b0;

  always #5 clk = ~clk;

  uart_rx_framed #(.CLKS_PER_BIT(BIT_CLKS)) dutA (
    .i_Clock      (clk),
    .i_Reset      (reset),
    .i_Rx_Serial  (rxA),
    .o_Rx_Valid   (validA),
    .i_Rx_Ready   (readyA),
    .o_Rx_Byte    (byteA),
    .o_Frame_Err  (ferrA),
    .o_Parity_Err (perrA),
    .o_Overrun    (ovrA),
    .o_Busy       (busyA)
  );

  uart_rx_framed #(
    .CLKS_PER_BIT (BIT_CLKS),
    .DATA_BITS    (7),
    .STOP_BITS    (2),
    .PARITY_MODE  (2)
  ) dutB (
    .i_Clock      (clk),
    .i_Reset      (reset),
    .i_Rx_Serial  (rxB),
    .o_Rx_Valid   (validB),
    .i_Rx_Ready   (readyB),
    .o_Rx_Byte    (byteB),
    .o_Frame_Err  (ferrB),
    .o_Parity_Err (perrB),
    .o_Overrun    (ovrB),
    .o_Busy       (busyB)
  );

  // Capture every accepted frame as {frame_err, parity_err, byte} and count valid rising edges.
  always @(negedge clk) begin
    if (validA && readyA) gotA.push_back({ferrA, perrA, byteA});
    if (validB && readyB) gotB.push_back({ferrB, perrB, byteB});
    if (validA && !validAPrev) validRisesA++;
    validAPrev = validA;
  end

  // Expected delivery for an 8N1 frame: data as sent, framing error when the stop bit is low.
  function automatic logic [9:0] modelA(input logic [7:0] d, input logic stopBit);
    return {!stopBit, 1'b0, d};
  endfunction

  // Line carries start, 7 data bits, p, s1, s2; interpretation depends on whether parity is built.
  function automatic logic [9:0] modelB(input logic [6:0] d, input logic p, input logic s1,
                                        input logic s2);
    int ones;
    logic fe, pe;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += int'(d[i]);
`ifdef UART_RX_PARITY_EN
    ones += int'(p);
    pe = (ones % 2) != 0;
    fe = !(s1 && s2);
`else
    pe = 1'b0;
    fe = !(p && s1);
    if (s2 == 1'b0) fe = fe;
`endif
    return {fe, pe, 1'b0, d};
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxA = bits[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    rxA = 1'b1;
  endtask

  task automatic applyStimulusB(input logic [6:0] d, input logic p, input logic s1,
                                input logic s2);
    logic [10:0] bits;
    bits = {s2, s1, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rxB = bits[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    rxB = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(5);
    vecCount++; if (validA !== 1'b0) begin errCount++; $display("[TB] FAIL reset_validA got %b want 0", validA); end
    vecCount++; if (byteA !== 8'h00) begin errCount++; $display("[TB] FAIL reset_byteA got %h want 00", byteA); end
    vecCount++; if (ferrA !== 1'b0) begin errCount++; $display("[TB] FAIL reset_ferrA got %b want 0", ferrA); end
    vecCount++; if (perrA !== 1'b0) begin errCount++; $display("[TB] FAIL reset_perrA got %b want 0", perrA); end
    vecCount++; if (ovrA !== 1'b0) begin errCount++; $display("[TB] FAIL reset_ovrA got %b want 0", ovrA); end
    vecCount++; if (busyA !== 1'b0) begin errCount++; $display("[TB] FAIL reset_busyA got %b want 0", busyA); end
    vecCount++; if (validB !== 1'b0) begin errCount++; $display("[TB] FAIL reset_validB got %b want 0", validB); end
    vecCount++; if (busyB !== 1'b0) begin errCount++; $display("[TB] FAIL reset_busyB got %b want 0", busyB); end
    reset = 1'b0;
    idle(5);
    vecCount++; if (busyA !== 1'b0) begin errCount++; $display("[TB] FAIL idle_busyA got %b want 0", busyA); end
  endtask

  task automatic checkFrameA(input string name, input logic [9:0] exp);
    int waited;
    logic [9:0] got;
    waited = 0;
    while (gotA.size() == 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    vecCount++;
    if (gotA.size() == 0) begin
      errCount++;
      $display("[TB] FAIL %s no frame delivered within 200 cycles, want %h", name, exp);
    end else begin
      got = gotA.pop_front();
      if (got !== exp) begin
        errCount++;
        $display("[TB] FAIL %s got {fe,pe,byte}=%h want %h", name, got, exp);
      end
    end
  endtask

  task automatic test_basic;
    int rises0;
    logic [7:0] d;
    logic s;
    readyA = 1'b1;
    rises0 = validRisesA;
    applyStimulus(8'hA5, 1'b1);
    idle(20);
    checkFrameA("basic_A5", {2'b00, 8'hA5});
    vecCount++;
    if (validRisesA - rises0 != 1) begin
      errCount++;
      $display("[TB] FAIL basic_pulses got %0d want 1", validRisesA - rises0);
    end
    vecCount++; if (validA !== 1'b0) begin errCount++; $display("[TB] FAIL basic_valid_drop got %b want 0", validA); end
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      applyStimulus(d, s);
      idle(24);
      checkFrameA("random_A", modelA(d, s));
    end
  endtask

  task automatic test_frame_err;
    int rises0;
    rises0 = validRisesA;
    applyStimulus(8'h3C, 1'b0);
    idle(40);
    checkFrameA("frame_err_3C", {2'b10, 8'h3C});
    vecCount++;
    if (validRisesA - rises0 != 1) begin
      errCount++;
      $display("[TB] FAIL frame_err_pulses got %0d want 1", validRisesA - rises0);
    end
  endtask

  task automatic test_glitch;
    int rises0;
    rises0 = validRisesA;
    rxA = 1'b0;
    idle(4);
    vecCount++; if (busyA !== 1'b1) begin errCount++; $display("[TB] FAIL glitch_busy got %b want 1", busyA); end
    rxA = 1'b1;
    idle(40);
    vecCount++; if (busyA !== 1'b0) begin errCount++; $display("[TB] FAIL glitch_idle got %b want 0", busyA); end
    vecCount++;
    if (validRisesA != rises0 || gotA.size() != 0) begin
      errCount++;
      $display("[TB] FAIL glitch_no_valid got %0d pulses want 0", validRisesA - rises0);
    end
  endtask

  task automatic test_back_to_back;
    readyA = 1'b0;
    vecCount++; if (ovrA !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_ovr_before got %b want 0", ovrA); end
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    idle(20);
    vecCount++; if (validA !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_valid got %b want 1", validA); end
    vecCount++; if (byteA !== 8'h11) begin errCount++; $display("[TB] FAIL b2b_byte got %h want 11", byteA); end
    vecCount++; if (ovrA !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_ovr got %b want 1", ovrA); end
    vecCount++; if (ferrA !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_ferr got %b want 0", ferrA); end
    readyA = 1'b1;
    idle(1);
    readyA = 1'b0;
    vecCount++; if (validA !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_valid_drop got %b want 0", validA); end
    checkFrameA("b2b_accept", {2'b00, 8'h11});
    vecCount++; if (gotA.size() != 0) begin errCount++; $display("[TB] FAIL b2b_extra got %0d frames want 0", gotA.size()); end
    idle(10);
    vecCount++; if (ovrA !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_ovr_sticky got %b want 1", ovrA); end
  endtask

  task automatic test_reset_midframe;
    logic [8:0] bits;
    int rises0;
    readyA = 1'b1;
    bits = {8'h77, 1'b0};
    rises0 = validRisesA;
    for (int i = 0; i < 4; i++) begin
      rxA = bits[i];
      repeat ((i == 3) ? BIT_CLKS / 2 : BIT_CLKS) @(posedge clk);
      #1;
    end
    rxA = 1'b1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    vecCount++; if (busyA !== 1'b0) begin errCount++; $display("[TB] FAIL midrst_busy got %b want 0", busyA); end
    vecCount++; if (ovrA !== 1'b0) begin errCount++; $display("[TB] FAIL midrst_ovr got %b want 0", ovrA); end
    idle(200);
    vecCount++;
    if (validRisesA != rises0 || gotA.size() != 0) begin
      errCount++;
      $display("[TB] FAIL midrst_no_output got %0d pulses want 0", validRisesA - rises0);
    end
    applyStimulus(8'h5A, 1'b1);
    idle(20);
    checkFrameA("midrst_5A", {2'b00, 8'h5A});
  endtask

  task automatic test_parity;
    logic [6:0] d;
    logic p, s1;
    logic [9:0] exp, got;
    int waited;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        d = 7'h41; p = 1'b1; s1 = 1'b1;
      end else begin
        d = 7'($urandom); p = 1'($urandom); s1 = ($urandom_range(0, 3) != 0);
      end
      exp = modelB(d, p, s1, 1'b1);
      applyStimulusB(d, p, s1, 1'b1);
      idle(30);
      waited = 0;
      while (gotB.size() == 0 && waited < 200) begin
        @(posedge clk);
        waited++;
      end
      vecCount++;
      if (gotB.size() == 0) begin
        errCount++;
        $display("[TB] FAIL parity_%0d no frame delivered within 200 cycles, want %h", k, exp);
      end else begin
        got = gotB.pop_front();
        if (got !== exp) begin
          errCount++;
          $display("[TB] FAIL parity_%0d got {fe,pe,byte}=%h want %h", k, got, exp);
        end
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    rxA    = 1'b1;
    rxB    = 1'b1;
    readyA = 1'b1;
    readyB = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
